// File: rtl/result_uart_tx.sv
// result_uart_tx: sends a 16-bit result as unsigned decimal ASCII plus CR LF over an 8N1 UART line
module result_uart_tx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        result_valid,
  input  logic [15:0] result,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        tx
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [2:0] {IDLE, CONVERT, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [BW-1:0] baud;
  logic [2:0] bit_cnt, idx, first;
  logic [4:0] conv_cnt;
  logic [15:0] bin;
  logic [19:0] bcd;
  logic [3:0] dig;
  logic [7:0] chr;
  logic baud_end, done_n;
  function automatic logic [19:0] adj(input logic [19:0] b);
    logic [19:0] r;
    for (int i = 0; i < 5; i++) r[4*i+:4] = b[4*i+:4] >= 4'd5 ? b[4*i+:4] + 4'd3 : b[4*i+:4];
    return r;
  endfunction
  assign baud_end = baud == BW'(CLKS_PER_BIT - 1);
  assign first = bcd[19:16] != 4'd0 ? 3'd0 : bcd[15:12] != 4'd0 ? 3'd1 :
                 bcd[11:8] != 4'd0 ? 3'd2 : bcd[7:4] != 4'd0 ? 3'd3 : 3'd4;
  assign dig = 4'(bcd >> (5'd16 - {idx, 2'b00}));
  assign chr = idx == 3'd5 ? 8'h0D : idx == 3'd6 ? 8'h0A : {4'h3, dig};
  assign tx = state == START ? 1'b0 : state == DATA ? chr[bit_cnt] : 1'b1;
  assign ready = state == IDLE;
  assign busy = ~ready;
  // Next state; the step from a stop bit to the next start bit costs no cycle
  always_comb begin
    state_n = state;
    done_n = 1'b0;
    case (state)
      IDLE:    state_n = result_valid ? CONVERT : IDLE;
      CONVERT: state_n = conv_cnt == 5'd16 ? START : CONVERT;
      START:   state_n = baud_end ? DATA : START;
      DATA:    state_n = baud_end && bit_cnt == 3'd7 ? STOP : DATA;
      STOP: begin
        state_n = baud_end ? (idx == 3'd6 ? IDLE : START) : STOP;
        done_n = baud_end && idx == 3'd6;
      end
      default: state_n = IDLE;
    endcase
  end
  // State, double-dabble conversion and bit/char/baud counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done <= 1'b0;
      baud <= '0;
      bit_cnt <= '0;
      idx <= '0;
      conv_cnt <= '0;
      bin <= '0;
      bcd <= '0;
    end else begin
      state <= state_n;
      done <= done_n;
      baud <= (state == START || state == DATA || state == STOP) && !baud_end ? baud + 1'b1 : '0;
      if (state == IDLE && result_valid) begin
        bin <= result;
        bcd <= '0;
        conv_cnt <= '0;
        bit_cnt <= '0;
      end
      if (state == CONVERT && conv_cnt != 5'd16) begin
        {bcd, bin} <= {adj(bcd), bin} << 1;
        conv_cnt <= conv_cnt + 5'd1;
      end
      if (state == CONVERT && conv_cnt == 5'd16) idx <= first;
      if (state == DATA && baud_end) bit_cnt <= bit_cnt + 3'd1;
      if (state == STOP && baud_end) idx <= idx + 3'd1;
    end
  end
endmodule

// File: tb/tb_result_uart_tx.sv
// tb_result_uart_tx: directed checks of decimal framing, bit timing, drop-while-busy and async reset
module tb_result_uart_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic result_valid = 1'b0;
  logic [15:0] result = '0;
  logic ready, busy, done, tx;
  int n_cmp = 0;
  int n_err = 0;
  result_uart_tx #(.CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .result_valid(result_valid), .result(result),
    .ready(ready), .busy(busy), .done(done), .tx(tx)
  );
  always #5 clk = ~clk;
  task automatic accept(input logic [15:0] v);
    @(negedge clk);
    result = v;
    result_valid = 1'b1;
    @(posedge clk); #1;
    result_valid = 1'b0;
  endtask
  // Starts 1 time unit after the accept edge; ends 1 time unit after the final stop-bit edge
  task automatic check_frame(input int n, input logic [55:0] exp, input string name);
    logic [9:0] bits;
    logic [7:0] ch;
    int pre_bad, hold_bad, done_bad;
    n_cmp++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      n_err++;
      $display("FAIL %s accept: busy=%b ready=%b want 1/0", name, busy, ready);
    end
    pre_bad = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || done !== 1'b0) pre_bad++;
    end
    n_cmp++;
    if (pre_bad !== 0) begin
      n_err++;
      $display("FAIL %s convert_idle: %0d bad cycles want 0", name, pre_bad);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (tx !== 1'b0) begin
      n_err++;
      $display("FAIL %s start_at_E17: tx=%b want 0", name, tx);
    end
    for (int c = 0; c < n; c++) begin
      hold_bad = 0;
      done_bad = 0;
      for (int b = 0; b < 10; b++) begin
        bits[b] = tx;
        for (int k = 0; k < 4; k++) begin
          if (tx !== bits[b]) hold_bad++;
          if (done !== 1'b0) done_bad++;
          @(posedge clk); #1;
        end
      end
      ch = bits[8:1];
      n_cmp++;
      if ({bits[9], bits[0]} !== 2'b10 || hold_bad != 0 || done_bad != 0) begin
        n_err++;
        $display("FAIL %s framing[%0d]: stop/start=%b hold_bad=%0d done_bad=%0d want 10/0/0",
                 name, c, {bits[9], bits[0]}, hold_bad, done_bad);
      end
      n_cmp++;
      if (ch !== exp[55-8*c -: 8]) begin
        n_err++;
        $display("FAIL %s char[%0d]: got %h want %h", name, c, ch, exp[55-8*c -: 8]);
      end
    end
    n_cmp++;
    if (done !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
      n_err++;
      $display("FAIL %s frame_end: done=%b ready=%b busy=%b tx=%b want 1/1/0/1", name, done, ready, busy, tx);
    end
  endtask
  task automatic check_after_done(input string name);
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || ready !== 1'b1 || tx !== 1'b1) begin
      n_err++;
      $display("FAIL %s after_done: done=%b ready=%b tx=%b want 0/1/1", name, done, ready, tx);
    end
  endtask
  task automatic test_reset;
    #2;
    n_cmp++;
    if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset: tx=%b ready=%b busy=%b done=%b want 1/1/0/0", tx, ready, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_values;
    accept(16'd12345); check_frame(7, 56'h31323334350D0A, "v12345"); check_after_done("v12345");
    accept(16'd0);     check_frame(3, 56'h300D0A_00000000, "v0"); check_after_done("v0");
    accept(16'd100);   check_frame(5, 56'h3130300D0A_0000, "v100"); check_after_done("v100");
    accept(16'd65535); check_frame(7, 56'h36353533350D0A, "v65535"); check_after_done("v65535");
  endtask
  task automatic test_timing;
    accept(16'd7); check_frame(3, 56'h370D0A_00000000, "v7"); check_after_done("v7");
  endtask
  task automatic test_drop_while_busy;
    accept(16'd42);
    fork
      check_frame(4, 56'h34320D0A_000000, "v42");
      begin
        repeat (30) @(negedge clk);
        result = 16'd999;
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
      end
    join
    check_after_done("v42_no_queue");
    accept(16'd999); check_frame(5, 56'h3939390D0A_0000, "v999"); check_after_done("v999");
  endtask
  task automatic test_async_reset;
    int done_seen;
    accept(16'd12345);
    repeat (62) @(posedge clk);
    #1;
    n_cmp++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_bit0: tx=%b busy=%b want 0/1", tx, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (tx !== 1'b1 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL rst_async: tx=%b ready=%b busy=%b done=%b want 1/1/0/0", tx, ready, busy, done);
    end
    done_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || tx !== 1'b1) done_seen++;
    end
    n_cmp++;
    if (done_seen !== 0) begin
      n_err++;
      $display("FAIL rst_hold: %0d bad cycles want 0", done_seen);
    end
    @(negedge clk);
    rst_n = 1'b1;
    accept(16'd5); check_frame(3, 56'h350D0A_00000000, "v5_after_rst"); check_after_done("v5_after_rst");
  endtask
  task automatic test_back_to_back;
    @(negedge clk);
    result = 16'd1;
    result_valid = 1'b1;
    @(posedge clk); #1;
    check_frame(3, 56'h310D0A_00000000, "hold1_a");
    @(posedge clk); #1;
    check_frame(3, 56'h310D0A_00000000, "hold1_b");
    result_valid = 1'b0;
    check_after_done("hold1_b");
  endtask
  initial begin
    test_reset;
    test_values;
    test_timing;
    test_drop_while_busy;
    test_async_reset;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
Output-side counterpart to the coefficient-entry/integration FSM. That FSM consumes operands from switches and produces a 16-bit integration result; this block takes the finished result and emits it over a UART TX line as unsigned decimal ASCII, with leading zeros suppressed and a CR LF terminator. It sits between the integration FSM's result register and the board's USB-UART pin.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 2

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
result_valid  input  1  one-cycle (or held) request to transmit result
result  input  16  unsigned value to transmit; sampled when accepted
ready  output  1  high when idle and able to accept result_valid
busy  output  1  high from acceptance until frame end (always equals ~ready)
done  output  1  one-cycle pulse when the final stop bit completes
tx  output  1  UART line, idle high, 8N1, LSB first

Behaviour:
- Reset (async, rst_n=0): tx=1, ready=1, busy=0, done=0, all counters and state cleared. Reset mid-frame aborts the frame immediately; no partial character is resumed.
- Accept: on an edge where result_valid=1 and ready=1, result is captured (edge E0), ready drops and busy rises. result_valid while busy is ignored and dropped, not queued.
- States: IDLE -> CONVERT -> START -> DATA -> STOP -> NEXT -> START ... -> IDLE.
- CONVERT: double-dabble binary-to-BCD, 16 shift iterations on edges E1..E16, producing 5 BCD digits d4..d0 (d4 = ten-thousands).
- Leading-zero suppression: the first character sent is the most significant non-zero digit. Zeros after it are always sent. Value 0 sends the single character '0'.
- Character sequence: suppressed digits as 0x30+d, then 0x0D, then 0x0A. Frame length is 3..7 characters.
- START: tx goes low on edge E17 for the first character and stays low for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each bit CLKS_PER_BIT cycles.
- STOP: tx=1 for CLKS_PER_BIT cycles.
- NEXT: selects the next character with zero extra cycles; the next start bit begins on the edge immediately after the stop bit ends. The line stays continuous with no idle gaps between characters.
- Frame end: on the edge that ends the last stop bit, the block returns to IDLE. On that edge done=1 for exactly one cycle, ready=1 and busy=0. A result_valid on the following edge is accepted.
- Width rules: bit counter is 3 bits, character index is 3 bits, baud counter is ceil(log2(CLKS_PER_BIT)) bits. Arithmetic is unsigned with no overflow possible.
- result changing after acceptance has no effect, because the value is captured at E0.

Test Plan:
- CLKS_PER_BIT=4, result=12345 -> tx carries 0x31 0x32 0x33 0x34 0x35 0x0D 0x0A, 7 frames = 280 clocks from E17. done pulses once, then ready=1.
- result=0 -> 0x30 0x0D 0x0A only. result=100 -> 0x31 0x30 0x30 0x0D 0x0A. result=65535 -> 0x36 0x35 0x35 0x33 0x35 0x0D 0x0A.
- Timing check (CLKS_PER_BIT=4, result=7): tx falls exactly on E17. Every bit is held exactly 4 clocks. No idle cycle between characters. done is high for one cycle on the edge at E17+120.
- result_valid pulsed with result=999 while busy on a frame for 42 -> only "42"CRLF is sent, and 999 is never transmitted. A later result_valid while ready=1 sends "999"CRLF.
- rst_n pulled low mid-data-bit of the 2nd character -> tx=1 immediately without waiting for clk, ready=1, no done pulse. After release, result=5 produces a clean 0x35 0x0D 0x0A.
- result_valid held high continuously with result=1 -> back-to-back frames "1"CRLF. Each new frame is accepted on the edge after done, and E17 timing is restarted for each frame.
